// File: rtl/ram_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_ctrl_pkg
// Brief    : Shared widths, request record and helpers for ram_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package ram_access_ctrl_pkg;

    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_DATA_W = 16;
    localparam int RSP_DEPTH      = 2;
    localparam int RSP_CNT_W      = $clog2(RSP_DEPTH + 1);
    localparam int NUM_CLIENTS    = 2;
    localparam int CLIENT_A       = 0;
    localparam int CLIENT_B       = 1;

    typedef struct packed {
        logic                      we;
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] wdata;
    } req_t;

    // Two writes to one address in the same cycle: port A takes priority.
    function automatic logic write_collision(
        input logic a_valid,
        input req_t a_req,
        input logic b_valid,
        input req_t b_req
    );
        return a_valid && b_valid && a_req.we && b_req.we && (a_req.addr == b_req.addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_access_ctrl_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rsp_fifo
// Brief    : Small synchronous FIFO with valid/ready on both sides and an
//            occupancy count; DEPTH must be a power of two.
// Revision : 1.0 - initial release
// ============================================================================
module rsp_fifo
    import ram_access_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_W,
    parameter int DEPTH = RSP_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_ctrl
// Brief    : Two-client request/response controller for a dual-port RAM with
//            registered RAM drive, credit-based read flow control and
//            same-address write arbitration (port A wins).
// Revision : 1.0 - initial release
// ============================================================================
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rsp_rdata,

    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_write_addr_a,
    output logic [DATA_W-1:0] ram_write_data_a,
    output logic [ADDR_W-1:0] ram_read_addr_a,
    input  logic [DATA_W-1:0] ram_read_data_a,

    output logic              ram_we_b,
    output logic [ADDR_W-1:0] ram_write_addr_b,
    output logic [DATA_W-1:0] ram_write_data_b,
    output logic [ADDR_W-1:0] ram_read_addr_b,
    input  logic [DATA_W-1:0] ram_read_data_b
);

    req_t                   w_req        [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] w_req_valid;
    logic [NUM_CLIENTS-1:0] w_req_ready;
    logic [NUM_CLIENTS-1:0] w_rsp_valid;
    logic [NUM_CLIENTS-1:0] w_rsp_ready;
    logic [NUM_CLIENTS-1:0] w_ram_we;
    logic [DATA_W-1:0]      w_rsp_rdata  [NUM_CLIENTS];
    logic [DATA_W-1:0]      w_ram_rdata  [NUM_CLIENTS];
    logic [DATA_W-1:0]      w_ram_wdata  [NUM_CLIENTS];
    logic [ADDR_W-1:0]      w_ram_waddr  [NUM_CLIENTS];
    logic [ADDR_W-1:0]      w_ram_raddr  [NUM_CLIENTS];
    logic                   w_collision;

    assign w_req[CLIENT_A]       = '{we: a_req_we, addr: a_req_addr, wdata: a_req_wdata};
    assign w_req[CLIENT_B]       = '{we: b_req_we, addr: b_req_addr, wdata: b_req_wdata};
    assign w_req_valid           = {b_req_valid, a_req_valid};
    assign w_rsp_ready           = {b_rsp_ready, a_rsp_ready};
    assign w_ram_rdata[CLIENT_A] = ram_read_data_a;
    assign w_ram_rdata[CLIENT_B] = ram_read_data_b;

    assign w_collision = write_collision(a_req_valid, w_req[CLIENT_A],
                                         b_req_valid, w_req[CLIENT_B]);

    generate
        for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
            logic                 r_ram_we;
            logic [ADDR_W-1:0]    r_waddr;
            logic [DATA_W-1:0]    r_wdata;
            logic [ADDR_W-1:0]    r_raddr;
            logic                 r_inflight;
            logic [RSP_CNT_W-1:0] w_fifo_count;
            logic                 w_fifo_in_ready;
            logic                 w_stall;
            logic                 w_credit_ok;
            logic                 w_accept_wr;
            logic                 w_accept_rd;

            // Only port B yields on a collision; port A is never stalled.
            assign w_stall     = (i == CLIENT_B) && w_collision;
            // Reads reserve a FIFO slot at acceptance, counting the one in flight.
            assign w_credit_ok = (RSP_CNT_W'(r_inflight) + w_fifo_count) < RSP_CNT_W'(RSP_DEPTH);
            assign w_req_ready[i] = rst_n && (w_req[i].we ? !w_stall : w_credit_ok);
            assign w_accept_wr = w_req_valid[i] && w_req_ready[i] && w_req[i].we;
            assign w_accept_rd = w_req_valid[i] && w_req_ready[i] && !w_req[i].we;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ram_we   <= 1'b0;
                    r_waddr    <= '0;
                    r_wdata    <= '0;
                    r_raddr    <= '0;
                    r_inflight <= 1'b0;
                end else begin
                    r_ram_we   <= w_accept_wr;
                    r_inflight <= w_accept_rd;
                    if (w_accept_wr) begin
                        r_waddr <= w_req[i].addr;
                        r_wdata <= w_req[i].wdata;
                    end
                    if (w_accept_rd) begin
                        r_raddr <= w_req[i].addr;
                    end
                end
            end

            rsp_fifo #(
                .WIDTH (DATA_W),
                .DEPTH (RSP_DEPTH),
                .CNT_W (RSP_CNT_W)
            ) u_rsp_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (r_inflight && w_fifo_in_ready),
                .in_ready  (w_fifo_in_ready),
                .in_data   (w_ram_rdata[i]),
                .out_valid (w_rsp_valid[i]),
                .out_ready (w_rsp_ready[i]),
                .out_data  (w_rsp_rdata[i]),
                .count     (w_fifo_count)
            );

            assign w_ram_we[i]    = r_ram_we;
            assign w_ram_waddr[i] = r_waddr;
            assign w_ram_wdata[i] = r_wdata;
            assign w_ram_raddr[i] = r_raddr;
        end
    endgenerate

    assign a_req_ready      = w_req_ready[CLIENT_A];
    assign b_req_ready      = w_req_ready[CLIENT_B];
    assign a_rsp_valid      = w_rsp_valid[CLIENT_A];
    assign b_rsp_valid      = w_rsp_valid[CLIENT_B];
    assign a_rsp_rdata      = w_rsp_rdata[CLIENT_A];
    assign b_rsp_rdata      = w_rsp_rdata[CLIENT_B];
    assign ram_we_a         = w_ram_we[CLIENT_A];
    assign ram_we_b         = w_ram_we[CLIENT_B];
    assign ram_write_addr_a = w_ram_waddr[CLIENT_A];
    assign ram_write_addr_b = w_ram_waddr[CLIENT_B];
    assign ram_write_data_a = w_ram_wdata[CLIENT_A];
    assign ram_write_data_b = w_ram_wdata[CLIENT_B];
    assign ram_read_addr_a  = w_ram_raddr[CLIENT_A];
    assign ram_read_addr_b  = w_ram_raddr[CLIENT_B];

endmodule
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_access_ctrl
// Brief    : Directed table-driven bench for ram_access_ctrl with a behavioural
//            dual-port RAM (posedge write, negedge read launch).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_access_ctrl;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
    logic [3:0]  a_req_addr, b_req_addr;
    logic [15:0] a_req_wdata, b_req_wdata, a_rsp_rdata, b_rsp_rdata;
    logic        ram_we_a, ram_we_b;
    logic [3:0]  ram_write_addr_a, ram_write_addr_b, ram_read_addr_a, ram_read_addr_b;
    logic [15:0] ram_write_data_a, ram_write_data_b;
    logic [15:0] ram_read_data_a, ram_read_data_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.ADDR_W(4), .DATA_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .a_req_valid      (a_req_valid),
        .a_req_ready      (a_req_ready),
        .a_req_we         (a_req_we),
        .a_req_addr       (a_req_addr),
        .a_req_wdata      (a_req_wdata),
        .a_rsp_valid      (a_rsp_valid),
        .a_rsp_ready      (a_rsp_ready),
        .a_rsp_rdata      (a_rsp_rdata),
        .b_req_valid      (b_req_valid),
        .b_req_ready      (b_req_ready),
        .b_req_we         (b_req_we),
        .b_req_addr       (b_req_addr),
        .b_req_wdata      (b_req_wdata),
        .b_rsp_valid      (b_rsp_valid),
        .b_rsp_ready      (b_rsp_ready),
        .b_rsp_rdata      (b_rsp_rdata),
        .ram_we_a         (ram_we_a),
        .ram_write_addr_a (ram_write_addr_a),
        .ram_write_data_a (ram_write_data_a),
        .ram_read_addr_a  (ram_read_addr_a),
        .ram_read_data_a  (ram_read_data_a),
        .ram_we_b         (ram_we_b),
        .ram_write_addr_b (ram_write_addr_b),
        .ram_write_data_b (ram_write_data_b),
        .ram_read_addr_b  (ram_read_addr_b),
        .ram_read_data_b  (ram_read_data_b)
    );

    // Behavioural dual-port RAM
    logic [15:0] mem [16];

    always @(posedge clk) begin
        if (ram_we_a) mem[ram_write_addr_a] <= ram_write_data_a;
        if (ram_we_b) mem[ram_write_addr_b] <= ram_write_data_b;
    end

    always @(negedge clk) begin
        ram_read_data_a <= mem[ram_read_addr_a];
        ram_read_data_b <= mem[ram_read_addr_b];
    end

    typedef struct packed {
        logic        a_v;
        logic        a_we;
        logic [3:0]  a_addr;
        logic [15:0] a_wd;
        logic        b_v;
        logic        b_we;
        logic [3:0]  b_addr;
        logic [15:0] b_wd;
        logic        e_ar;
        logic        e_br;
        logic        e_wa;
        logic        e_wb;
        logic        e_av;
        logic [15:0] e_ad;
        logic        e_bv;
        logic [15:0] e_bd;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(
        input logic a_v, input logic a_we, input logic [3:0] a_addr, input logic [15:0] a_wd,
        input logic a_rr,
        input logic b_v, input logic b_we, input logic [3:0] b_addr, input logic [15:0] b_wd,
        input logic b_rr
    );
        a_req_valid = a_v;  a_req_we = a_we;  a_req_addr = a_addr;  a_req_wdata = a_wd;
        a_rsp_ready = a_rr;
        b_req_valid = b_v;  b_req_we = b_we;  b_req_addr = b_addr;  b_req_wdata = b_wd;
        b_rsp_ready = b_rr;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " req_ready"}, 64'({a_req_ready, b_req_ready}), 64'd0);
        check({tag, " rsp_valid"}, 64'({a_rsp_valid, b_rsp_valid}), 64'd0);
        check({tag, " rsp_rdata"}, 64'({a_rsp_rdata, b_rsp_rdata}), 64'd0);
        check({tag, " ram_we"}, 64'({ram_we_a, ram_we_b}), 64'd0);
        check({tag, " ram_addrs"}, 64'({ram_write_addr_a, ram_write_addr_b,
                                        ram_read_addr_a, ram_read_addr_b}), 64'd0);
        check({tag, " ram_wdata"}, 64'({ram_write_data_a, ram_write_data_b}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          a_v a_we addr   wdata        b_v b_we addr   wdata      ar br wa wb av a_data       bv b_data
        vecs[0]  = '{H, H, 4'd3, 16'hBEEF, L, L, 4'd0, 16'h0000, H, H, L, L, L, 16'h0000, L, 16'h0000};
        vecs[1]  = '{H, L, 4'd3, 16'h0000, L, L, 4'd0, 16'h0000, H, H, H, L, L, 16'h0000, L, 16'h0000};
        vecs[2]  = '{L, L, 4'd0, 16'h0000, L, L, 4'd0, 16'h0000, H, H, L, L, L, 16'h0000, L, 16'h0000};
        vecs[3]  = '{L, L, 4'd0, 16'h0000, L, L, 4'd0, 16'h0000, H, H, L, L, H, 16'hBEEF, L, 16'h0000};
        vecs[4]  = '{L, L, 4'd0, 16'h0000, L, L, 4'd0, 16'h0000, H, H, L, L, L, 16'h0000, L, 16'h0000};
        vecs[5]  = '{H, H, 4'd5, 16'h1111, H, H, 4'd5, 16'h2222, H, L, L, L, L, 16'h0000, L, 16'h0000};
        vecs[6]  = '{L, L, 4'd0, 16'h0000, H, H, 4'd5, 16'h2222, H, H, H, L, L, 16'h0000, L, 16'h0000};
        vecs[7]  = '{H, L, 4'd5, 16'h0000, L, L, 4'd0, 16'h0000, H, H, L, H, L, 16'h0000, L, 16'h0000};
        vecs[8]  = '{L, L, 4'd0, 16'h0000, L, L, 4'd0, 16'h0000, H, H, L, L, L, 16'h0000, L, 16'h0000};
        vecs[9]  = '{L, L, 4'd0, 16'h0000, L, L, 4'd0, 16'h0000, H, H, L, L, H, 16'h2222, L, 16'h0000};
        vecs[10] = '{H, H, 4'd7, 16'h00AA, L, L, 4'd0, 16'h0000, H, H, L, L, L, 16'h0000, L, 16'h0000};
        vecs[11] = '{L, L, 4'd0, 16'h0000, L, L, 4'd0, 16'h0000, H, H, H, L, L, 16'h0000, L, 16'h0000};
        vecs[12] = '{H, H, 4'd7, 16'h5555, H, L, 4'd7, 16'h0000, H, H, L, L, L, 16'h0000, L, 16'h0000};
        vecs[13] = '{L, L, 4'd0, 16'h0000, H, L, 4'd7, 16'h0000, H, H, H, L, L, 16'h0000, L, 16'h0000};
        vecs[14] = '{L, L, 4'd0, 16'h0000, L, L, 4'd0, 16'h0000, H, L, L, L, L, 16'h0000, H, 16'h00AA};
        vecs[15] = '{L, L, 4'd0, 16'h0000, L, L, 4'd0, 16'h0000, H, H, L, L, L, 16'h0000, H, 16'h5555};
        vecs[16] = '{L, L, 4'd0, 16'h0000, L, L, 4'd0, 16'h0000, H, H, L, L, L, 16'h0000, L, 16'h0000};

        // Reset state, with requests presented to prove ready stays low
        drive(H, L, 4'd1, 16'h0000, H, H, H, 4'd2, 16'h1234, H);
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        drive(L, L, 4'd0, 16'h0000, H, L, L, 4'd0, 16'h0000, H);
        #2 rst_n = 1'b1;

        for (int k = 0; k < NVEC; k++) begin
            tick();
            drive(vecs[k].a_v, vecs[k].a_we, vecs[k].a_addr, vecs[k].a_wd, H,
                  vecs[k].b_v, vecs[k].b_we, vecs[k].b_addr, vecs[k].b_wd, H);
            #1;
            check($sformatf("v%0d a_req_ready", k), 64'(a_req_ready), 64'(vecs[k].e_ar));
            check($sformatf("v%0d b_req_ready", k), 64'(b_req_ready), 64'(vecs[k].e_br));
            check($sformatf("v%0d ram_we_a", k), 64'(ram_we_a), 64'(vecs[k].e_wa));
            check($sformatf("v%0d ram_we_b", k), 64'(ram_we_b), 64'(vecs[k].e_wb));
            check($sformatf("v%0d a_rsp_valid", k), 64'(a_rsp_valid), 64'(vecs[k].e_av));
            check($sformatf("v%0d b_rsp_valid", k), 64'(b_rsp_valid), 64'(vecs[k].e_bv));
            if (vecs[k].e_av) check($sformatf("v%0d a_rsp_rdata", k), 64'(a_rsp_rdata), 64'(vecs[k].e_ad));
            if (vecs[k].e_bv) check($sformatf("v%0d b_rsp_rdata", k), 64'(b_rsp_rdata), 64'(vecs[k].e_bd));
            if (vecs[k].e_wa) begin
                check($sformatf("v%0d ram_write_addr_a", k), 64'(ram_write_addr_a), 64'(vecs[k-1].a_addr));
                check($sformatf("v%0d ram_write_data_a", k), 64'(ram_write_data_a), 64'(vecs[k-1].a_wd));
            end
        end

        // Backpressure: three reads on A with no pops
        tick(); drive(H, L, 4'd3, 16'h0000, L, L, L, 4'd0, 16'h0000, H); #1;
        check("bp rd0 ready", 64'(a_req_ready), 64'd1);
        tick(); drive(H, L, 4'd5, 16'h0000, L, L, L, 4'd0, 16'h0000, H); #1;
        check("bp rd1 ready", 64'(a_req_ready), 64'd1);
        tick(); drive(H, L, 4'd7, 16'h0000, L, L, L, 4'd0, 16'h0000, H); #1;
        check("bp rd2 stalled c2", 64'(a_req_ready), 64'd0);
        check("bp rsp valid c2", 64'(a_rsp_valid), 64'd1);
        check("bp rsp data c2", 64'(a_rsp_rdata), 64'hBEEF);
        tick(); drive(H, L, 4'd7, 16'h0000, H, L, L, 4'd0, 16'h0000, H); #1;
        check("bp rd2 stalled c3", 64'(a_req_ready), 64'd0);
        check("bp rsp0 data", 64'(a_rsp_rdata), 64'hBEEF);
        tick(); drive(H, L, 4'd7, 16'h0000, H, L, L, 4'd0, 16'h0000, H); #1;
        check("bp rd2 ready", 64'(a_req_ready), 64'd1);
        check("bp rsp1 valid", 64'(a_rsp_valid), 64'd1);
        check("bp rsp1 data", 64'(a_rsp_rdata), 64'h2222);
        tick(); drive(L, L, 4'd0, 16'h0000, H, L, L, 4'd0, 16'h0000, H); #1;
        check("bp gap valid", 64'(a_rsp_valid), 64'd0);
        tick(); #1;
        check("bp rsp2 valid", 64'(a_rsp_valid), 64'd1);
        check("bp rsp2 data", 64'(a_rsp_rdata), 64'h5555);
        tick(); #1;
        check("bp drained", 64'(a_rsp_valid), 64'd0);

        // Reset mid-operation: B has one read in flight and one buffered
        tick(); drive(L, L, 4'd0, 16'h0000, H, H, L, 4'd3, 16'h0000, L); #1;
        check("rst rd0 ready", 64'(b_req_ready), 64'd1);
        tick(); drive(H, H, 4'd9, 16'h1234, H, H, L, 4'd5, 16'h0000, L); #1;
        check("rst rd1 ready", 64'(b_req_ready), 64'd1);
        tick(); drive(L, L, 4'd0, 16'h0000, H, L, L, 4'd0, 16'h0000, L); #1;
        check("rst pending we", 64'(ram_we_a), 64'd1);
        check("rst buffered valid", 64'(b_rsp_valid), 64'd1);
        check("rst buffered data", 64'(b_rsp_rdata), 64'hBEEF);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid reset");
        repeat (2) tick();
        check_outputs_zero("held reset");
        rst_n = 1'b1;
        drive(L, L, 4'd0, 16'h0000, H, L, L, 4'd0, 16'h0000, H);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            check($sformatf("post reset %0d rsp_valid", k), 64'({a_rsp_valid, b_rsp_valid}), 64'd0);
            check($sformatf("post reset %0d ram_we", k), 64'({ram_we_a, ram_we_b}), 64'd0);
            check($sformatf("post reset %0d req_ready", k), 64'({a_req_ready, b_req_ready}), 64'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
